// File: rtl/song_reader_pkg.sv
// Shared widths, state encoding and ROM-word helpers for the song sequencer.
package song_reader_pkg;

  localparam int ADDR_W = 7;
  localparam int SONG_W = 2;
  localparam int IDX_W  = ADDR_W - SONG_W;
  localparam int NOTE_W = 6;
  localparam int DUR_W  = 6;
  localparam int WORD_W = NOTE_W + DUR_W;

  // A zero duration marks the end of a song's note list.
  localparam logic [DUR_W-1:0] DUR_END  = 6'd0;
  localparam logic [IDX_W-1:0] IDX_ZERO = 5'd0;
  localparam logic [IDX_W-1:0] IDX_ONE  = 5'd1;
  localparam logic [IDX_W-1:0] IDX_LAST = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_PLAY  = 2'd3
  } state_t;

  // True when the ROM word carries the end-of-song duration.
  function automatic logic is_end_marker(input logic [WORD_W-1:0] word);
    return (word[DUR_W-1:0] == DUR_END);
  endfunction

endpackage

// File: rtl/song_reader_if.sv
// Bundle of controller, ROM and note-player signals around the song reader.
interface song_reader_if;
  import song_reader_pkg::*;

  logic                play;
  logic [SONG_W-1:0]   song;
  logic                note_done;
  logic [ADDR_W-1:0]   rom_addr;
  logic [WORD_W-1:0]   rom_dout;
  logic [NOTE_W-1:0]   note;
  logic [DUR_W-1:0]    duration;
  logic                new_note;
  logic                song_done;

  // Environment side: controller, ROM and note player.
  modport master (
    output play, song, note_done, rom_dout,
    input  rom_addr, note, duration, new_note, song_done
  );

  // Sequencer side.
  modport slave (
    input  play, song, note_done, rom_dout,
    output rom_addr, note, duration, new_note, song_done
  );
endinterface

// File: rtl/song_reader.sv
// Song sequencer: walks a song's note list in the ROM, hands each note to the
// note player and advances one entry per note_done.
module song_reader
  import song_reader_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  song_reader_if.slave  bus
);

  state_t              state_r,     state_n;
  logic [IDX_W-1:0]    idx_r,       idx_n;
  logic [SONG_W-1:0]   song_q_r,    song_q_n;
  logic [NOTE_W-1:0]   note_r,      note_n;
  logic [DUR_W-1:0]    duration_r,  duration_n;
  logic                new_note_r,  new_note_n;
  logic                song_done_r, song_done_n;
  logic                song_changed_s;

  assign song_changed_s = (bus.song != song_q_r);

  assign bus.rom_addr  = {song_q_r, idx_r};
  assign bus.note      = note_r;
  assign bus.duration  = duration_r;
  assign bus.new_note  = new_note_r;
  assign bus.song_done = song_done_r;

  // Next-state, index and capture logic; a song change aborts the current entry.
  always_comb begin
    state_n     = state_r;
    idx_n       = idx_r;
    song_q_n    = song_q_r;
    note_n      = note_r;
    duration_n  = duration_r;
    new_note_n  = 1'b0;
    song_done_n = 1'b0;
    case (state_r)
      ST_IDLE: begin
        song_q_n = bus.song;
        if (bus.play) begin
          state_n = ST_FETCH;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (song_changed_s) begin
          song_q_n = bus.song;
          idx_n    = IDX_ZERO;
          state_n  = ST_IDLE;
        end else begin
          state_n  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (song_changed_s) begin
          song_q_n = bus.song;
          idx_n    = IDX_ZERO;
          state_n  = ST_IDLE;
        end else begin
          note_n     = bus.rom_dout[WORD_W-1:DUR_W];
          duration_n = bus.rom_dout[DUR_W-1:0];
          if (is_end_marker(bus.rom_dout)) begin
            song_done_n = 1'b1;
            idx_n       = IDX_ZERO;
            state_n     = ST_IDLE;
          end else begin
            new_note_n  = 1'b1;
            state_n     = ST_PLAY;
          end
        end
      end
      ST_PLAY: begin
        if (song_changed_s) begin
          song_q_n = bus.song;
          idx_n    = IDX_ZERO;
          state_n  = ST_IDLE;
        end else if (bus.note_done && bus.play) begin
          if (idx_r == IDX_LAST) begin
            song_done_n = 1'b1;
            idx_n       = IDX_ZERO;
            state_n     = ST_IDLE;
          end else begin
            idx_n       = idx_r + IDX_ONE;
            state_n     = ST_FETCH;
          end
        end else begin
          state_n = ST_PLAY;
        end
      end
      default: begin
        idx_n   = IDX_ZERO;
        state_n = ST_IDLE;
      end
    endcase
  end

  // State, index and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      idx_r       <= IDX_ZERO;
      song_q_r    <= 2'd0;
      note_r      <= 6'd0;
      duration_r  <= 6'd0;
      new_note_r  <= 1'b0;
      song_done_r <= 1'b0;
    end else begin
      state_r     <= state_n;
      idx_r       <= idx_n;
      song_q_r    <= song_q_n;
      note_r      <= note_n;
      duration_r  <= duration_n;
      new_note_r  <= new_note_n;
      song_done_r <= song_done_n;
    end
  end

endmodule

// File: tb/tb_song_reader.sv
// Directed bench for song_reader with a synchronous song ROM model and a
// bench-driven note player.
module tb_song_reader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   both_cnt = 0;
  int   done_cnt = 0;

  song_reader_if bus();

  song_reader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Known ROM image: song 0 ends at idx 28, song 2 uses all 32 entries.
  function automatic logic [11:0] rom_word(input logic [6:0] a);
    logic [1:0] s;
    logic [4:0] i;
    logic [5:0] n;
    logic [5:0] d;
    s = a[6:5];
    i = a[4:0];
    case (s)
      2'd0: begin
        if (i == 5'd0)       begin n = 6'd49; d = 6'd12; end
        else if (i == 5'd1)  begin n = 6'd1;  d = 6'd8;  end
        else if (i == 5'd28) begin n = 6'd0;  d = 6'd0;  end
        else                 begin n = {1'b0, i} + 6'd2; d = 6'd5; end
      end
      2'd1: begin n = {1'b0, i} + 6'd20; d = 6'd4; end
      2'd2: begin
        if (i == 5'd31) begin n = 6'd47; d = 6'd26; end
        else            begin n = {1'b0, i} + 6'd5; d = {1'b0, i} + 6'd1; end
      end
      default: begin
        if (i == 5'd0) begin n = 6'd42; d = 6'd32; end
        else           begin n = {1'b0, i}; d = 6'd7; end
      end
    endcase
    return {n, d};
  endfunction

  // Synchronous ROM: data valid one cycle after the address.
  always @(posedge clk) bus.rom_dout <= rom_word(bus.rom_addr);

  // Pulse monitor, sampling the registered outputs before they update.
  always @(posedge clk) begin
    if (bus.new_note && bus.song_done) both_cnt++;
    if (bus.song_done) done_cnt++;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.play = 1'b0;
    bus.note_done = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Ack n notes, then stop at the negedge where note n+1 is presented.
  task automatic ack_until(input int n, output bit ok);
    int seen;
    seen = 0;
    ok = 1'b0;
    for (int c = 0; c < 600 && !ok; c++) begin
      step();
      bus.note_done = 1'b0;
      if (bus.new_note) begin
        if (seen == n) ok = 1'b1;
        else begin seen++; bus.note_done = 1'b1; end
      end
    end
  endtask

  task automatic test_reset();
    bus.play = 1'b0; bus.song = 2'd0; bus.note_done = 1'b0;
    reset = 1'b1;
    step(); step();
    checks++;
    if (bus.rom_addr !== 7'd0 || bus.note !== 6'd0 || bus.duration !== 6'd0 ||
        bus.new_note !== 1'b0 || bus.song_done !== 1'b0) begin
      failures++;
      $display("FAIL reset: addr=%0d note=%0d dur=%0d nn=%b sd=%b expected all 0",
               bus.rom_addr, bus.note, bus.duration, bus.new_note, bus.song_done);
    end
    reset = 1'b0;
  endtask

  task automatic test_first_notes();
    do_reset();
    bus.song = 2'd0; bus.play = 1'b1;
    step();
    checks++;
    if (bus.rom_addr !== 7'd0 || bus.new_note !== 1'b0) begin
      failures++; $display("FAIL first_fetch: addr=%0d nn=%b expected 0 0", bus.rom_addr, bus.new_note);
    end
    step();
    checks++;
    if (bus.new_note !== 1'b0) begin
      failures++; $display("FAIL first_early: nn=%b expected 0", bus.new_note);
    end
    step();
    checks++;
    if (bus.new_note !== 1'b1 || bus.note !== 6'd49 || bus.duration !== 6'd12) begin
      failures++;
      $display("FAIL first_note: nn=%b note=%0d dur=%0d expected 1 49 12", bus.new_note, bus.note, bus.duration);
    end
    bus.note_done = 1'b1;
    step();
    bus.note_done = 1'b0;
    checks++;
    if (bus.rom_addr !== 7'd1 || bus.new_note !== 1'b0) begin
      failures++; $display("FAIL second_fetch: addr=%0d nn=%b expected 1 0", bus.rom_addr, bus.new_note);
    end
    step(); step();
    checks++;
    if (bus.new_note !== 1'b1 || bus.note !== 6'd1 || bus.duration !== 6'd8) begin
      failures++;
      $display("FAIL second_note: nn=%b note=%0d dur=%0d expected 1 1 8", bus.new_note, bus.note, bus.duration);
    end
  endtask

  task automatic test_song0_end();
    int nn;
    bit got;
    do_reset();
    bus.song = 2'd0; bus.play = 1'b1;
    nn = 0; got = 1'b0;
    for (int c = 0; c < 2000 && !got; c++) begin
      step();
      bus.note_done = 1'b0;
      if (bus.song_done) got = 1'b1;
      else if (bus.new_note) begin nn++; bus.note_done = 1'b1; end
    end
    checks++;
    if (!got || nn != 28) begin
      failures++; $display("FAIL song0_count: done=%b notes=%0d expected 1 28", got, nn);
    end
    checks++;
    if (bus.rom_addr !== 7'd0 || bus.new_note !== 1'b0 || bus.duration !== 6'd0) begin
      failures++;
      $display("FAIL song0_end: addr=%0d nn=%b dur=%0d expected 0 0 0", bus.rom_addr, bus.new_note, bus.duration);
    end
    step(); step(); step();
    checks++;
    if (bus.new_note !== 1'b1 || bus.note !== 6'd49 || bus.song_done !== 1'b0) begin
      failures++; $display("FAIL song0_loop: nn=%b note=%0d sd=%b expected 1 49 0", bus.new_note, bus.note, bus.song_done);
    end
  endtask

  task automatic test_song2_wrap();
    int nn, last_c, done_c;
    logic [5:0] last_note, last_dur;
    do_reset();
    bus.song = 2'd2; bus.play = 1'b1;
    nn = 0; last_c = -10; done_c = -1; last_note = 6'd0; last_dur = 6'd0;
    step();
    bus.note_done = 1'b0;
    checks++;
    if (bus.rom_addr !== 7'd64) begin
      failures++; $display("FAIL song2_start: addr=%0d expected 64", bus.rom_addr);
    end
    for (int c = 0; c < 2000 && done_c < 0; c++) begin
      step();
      bus.note_done = 1'b0;
      if (bus.song_done) done_c = c;
      else if (bus.new_note) begin
        nn++; last_c = c; last_note = bus.note; last_dur = bus.duration;
        bus.note_done = 1'b1;
      end
    end
    checks++;
    if (nn != 32 || last_note !== 6'd47 || last_dur !== 6'd26) begin
      failures++;
      $display("FAIL song2_notes: count=%0d last=%0d/%0d expected 32 47/26", nn, last_note, last_dur);
    end
    checks++;
    if (done_c != last_c + 1) begin
      failures++; $display("FAIL song2_done_latency: done_at=%0d expected %0d", done_c, last_c + 1);
    end
    checks++;
    if (bus.rom_addr !== 7'd64) begin
      failures++; $display("FAIL song2_wrap: addr=%0d expected 64", bus.rom_addr);
    end
  endtask

  task automatic test_song_change();
    bit ok;
    int done_base;
    do_reset();
    bus.song = 2'd1; bus.play = 1'b1;
    done_base = done_cnt;
    ack_until(5, ok);
    checks++;
    if (!ok || bus.rom_addr !== 7'd37 || bus.note !== 6'd25) begin
      failures++; $display("FAIL change_setup: ok=%b addr=%0d note=%0d expected 1 37 25", ok, bus.rom_addr, bus.note);
    end
    bus.song = 2'd3;
    bus.note_done = 1'b1;
    step();
    bus.note_done = 1'b0;
    checks++;
    if (bus.rom_addr !== 7'd96 || bus.new_note !== 1'b0 || bus.song_done !== 1'b0) begin
      failures++;
      $display("FAIL change_abort: addr=%0d nn=%b sd=%b expected 96 0 0", bus.rom_addr, bus.new_note, bus.song_done);
    end
    step(); step(); step();
    checks++;
    if (bus.new_note !== 1'b1 || bus.note !== 6'd42 || bus.duration !== 6'd32) begin
      failures++;
      $display("FAIL change_note: nn=%b note=%0d dur=%0d expected 1 42 32", bus.new_note, bus.note, bus.duration);
    end
    checks++;
    if (done_cnt != done_base) begin
      failures++; $display("FAIL change_no_done: song_done pulses=%0d expected 0", done_cnt - done_base);
    end
  endtask

  task automatic test_pause();
    bit ok;
    int stray;
    do_reset();
    bus.song = 2'd0; bus.play = 1'b1;
    ack_until(3, ok);
    checks++;
    if (!ok || bus.rom_addr !== 7'd3) begin
      failures++; $display("FAIL pause_setup: ok=%b addr=%0d expected 1 3", ok, bus.rom_addr);
    end
    bus.play = 1'b0;
    stray = 0;
    for (int k = 0; k < 4; k++) begin
      bus.note_done = 1'b1;
      step();
      bus.note_done = 1'b0;
      if (bus.new_note) stray++;
      step();
      if (bus.new_note) stray++;
    end
    checks++;
    if (bus.rom_addr !== 7'd3 || stray != 0) begin
      failures++; $display("FAIL pause_hold: addr=%0d new_notes=%0d expected 3 0", bus.rom_addr, stray);
    end
    bus.play = 1'b1;
    bus.note_done = 1'b1;
    step();
    bus.note_done = 1'b0;
    checks++;
    if (bus.rom_addr !== 7'd4) begin
      failures++; $display("FAIL pause_resume: addr=%0d expected 4", bus.rom_addr);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    bus.song = 2'd2; bus.play = 1'b1;
    ack_until(0, ok);
    bus.note_done = 1'b1;
    step();
    bus.note_done = 1'b0;
    step();
    checks++;
    if (!ok || bus.rom_addr !== 7'd65 || bus.note !== 6'd5) begin
      failures++; $display("FAIL midreset_setup: ok=%b addr=%0d note=%0d expected 1 65 5", ok, bus.rom_addr, bus.note);
    end
    reset = 1'b1;
    step();
    checks++;
    if (bus.rom_addr !== 7'd0 || bus.note !== 6'd0 || bus.duration !== 6'd0 ||
        bus.new_note !== 1'b0 || bus.song_done !== 1'b0) begin
      failures++;
      $display("FAIL midreset_clear: addr=%0d note=%0d dur=%0d nn=%b sd=%b expected all 0",
               bus.rom_addr, bus.note, bus.duration, bus.new_note, bus.song_done);
    end
    reset = 1'b0;
    step();
    checks++;
    if (bus.rom_addr !== 7'd64 || bus.new_note !== 1'b0) begin
      failures++; $display("FAIL midreset_resume: addr=%0d nn=%b expected 64 0", bus.rom_addr, bus.new_note);
    end
    step(); step();
    checks++;
    if (bus.new_note !== 1'b1 || bus.note !== 6'd5 || bus.duration !== 6'd1) begin
      failures++;
      $display("FAIL midreset_note: nn=%b note=%0d dur=%0d expected 1 5 1", bus.new_note, bus.note, bus.duration);
    end
  endtask

  initial begin
    bus.play = 1'b0;
    bus.song = 2'd0;
    bus.note_done = 1'b0;
    test_reset();
    test_first_notes();
    test_song0_end();
    test_song2_wrap();
    test_song_change();
    test_pause();
    test_reset_mid();
    checks++;
    if (both_cnt != 0) begin
      failures++; $display("FAIL pulse_overlap: cycles=%0d expected 0", both_cnt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
